// File: rtl/march_scheduler.sv
// march_scheduler: frame-level ray-march work sequencer.
// Walks the display in raster order, hands pixels to a pool of cores
// (one per cycle, round-robin) and gathers finished pixels round-robin
// into a single output stream. The fractal selection is latched for the
// whole frame, and frame boundaries are reported as single-cycle pulses.
//
// Handshakes: a core may take a pixel when core_ready_in[i] is high and
// the core has nothing in flight; core_start_out[i] is the one-cycle
// transfer. A result transfers when core_done_in[i] is high for an
// in-flight core; core_ack_out[i] (with valid_out and the pixel data) is
// the one-cycle transfer, and the core must drop done the next cycle.
module march_scheduler #(
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 240,
  parameter int NUM_CORES      = 4,
  parameter int H_BITS         = $clog2(DISPLAY_WIDTH),
  parameter int V_BITS         = $clog2(DISPLAY_HEIGHT)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  logic [2:0]                    fractal_sel_in,
  output logic                          busy_out,
  output logic                          new_frame_out,
  output logic                          frame_done_out,
  output logic [2:0]                    fractal_sel_out,
  input  logic [NUM_CORES-1:0]          core_ready_in,
  output logic [NUM_CORES-1:0]          core_start_out,
  output logic [H_BITS-1:0]             core_hcount_out,
  output logic [V_BITS-1:0]             core_vcount_out,
  input  logic [NUM_CORES-1:0]          core_done_in,
  input  logic [NUM_CORES*H_BITS-1:0]   core_hcount_in,
  input  logic [NUM_CORES*V_BITS-1:0]   core_vcount_in,
  input  logic [NUM_CORES*4-1:0]        core_color_in,
  output logic [NUM_CORES-1:0]          core_ack_out,
  output logic [H_BITS-1:0]             hcount_out,
  output logic [V_BITS-1:0]             vcount_out,
  output logic [3:0]                    color_out,
  output logic                          valid_out,
  output logic [1:0]                    state_dbg_out
);

  localparam int PTR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int PIXELS = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int RET_W  = $clog2(PIXELS + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [NUM_CORES-1:0]  r_inflight;
  logic [PTR_W-1:0]      r_disp_ptr;
  logic [PTR_W-1:0]      r_ret_ptr;
  logic [H_BITS-1:0]     r_h;
  logic [V_BITS-1:0]     r_v;
  logic [RET_W-1:0]      r_retired;
  logic [NUM_CORES-1:0]  r_core_start;
  logic [H_BITS-1:0]     r_core_h;
  logic [V_BITS-1:0]     r_core_v;
  logic [NUM_CORES-1:0]  r_core_ack;
  logic [H_BITS-1:0]     r_hout;
  logic [V_BITS-1:0]     r_vout;
  logic [3:0]            r_color;
  logic                  r_valid;
  logic                  r_new_frame;
  logic                  r_frame_done;
  logic [2:0]            r_fsel;

  logic                  w_frame_start;
  logic [NUM_CORES-1:0]  w_disp_req;
  logic [NUM_CORES-1:0]  w_disp_grant;
  logic                  w_disp_fire;
  logic                  w_last_pix;
  logic [NUM_CORES-1:0]  w_ret_req;
  logic [NUM_CORES-1:0]  w_ret_grant;
  logic                  w_ret_fire;
  logic [H_BITS-1:0]     w_ret_h;
  logic [V_BITS-1:0]     w_ret_v;
  logic [3:0]            w_ret_c;

  // First requester at or after ptr, wrapping around the pool.
  function automatic logic [NUM_CORES-1:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                                   input logic [PTR_W-1:0] ptr);
    logic [NUM_CORES-1:0] g;
    logic                 found;
    int                   idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  // Pointer value that makes the index after the granted one the first candidate.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [NUM_CORES-1:0] g);
    logic [PTR_W-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (g[i]) p = (i == NUM_CORES - 1) ? '0 : PTR_W'(i + 1);
    end
    return p;
  endfunction

  assign w_frame_start = (r_state == S_IDLE) && start_in;
  assign w_disp_req    = (r_state == S_DISPATCH) ? (core_ready_in & ~r_inflight) : '0;
  assign w_disp_grant  = rr_pick(w_disp_req, r_disp_ptr);
  assign w_disp_fire   = |w_disp_grant;
  assign w_last_pix    = (r_h == H_BITS'(DISPLAY_WIDTH - 1)) && (r_v == V_BITS'(DISPLAY_HEIGHT - 1));
  assign w_ret_req     = core_done_in & r_inflight & ~r_core_ack;
  assign w_ret_grant   = rr_pick(w_ret_req, r_ret_ptr);
  assign w_ret_fire    = |w_ret_grant;

  // Select the granted core's result slice.
  always_comb begin
    w_ret_h = '0;
    w_ret_v = '0;
    w_ret_c = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_ret_grant[i]) begin
        w_ret_h = core_hcount_in[i*H_BITS +: H_BITS];
        w_ret_v = core_vcount_in[i*V_BITS +: V_BITS];
        w_ret_c = core_color_in[i*4 +: 4];
      end
    end
  end

  // Frame FSM next state: start, last pixel issued, all pixels retired.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (start_in) w_next_state = S_DISPATCH;
      S_DISPATCH: if (w_disp_fire && w_last_pix) w_next_state = S_DRAIN;
      S_DRAIN:    if (r_retired == RET_W'(PIXELS)) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Frame FSM state register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Dispatch: raster counters, registered start pulse, in-flight bookkeeping.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_core_start <= '0;
      r_core_h     <= '0;
      r_core_v     <= '0;
      r_disp_ptr   <= '0;
      r_h          <= '0;
      r_v          <= '0;
      r_inflight   <= '0;
    end else begin
      r_core_start <= w_disp_grant;
      // A core stays in flight until the end of its ack cycle.
      r_inflight   <= (r_inflight & ~r_core_ack) | w_disp_grant;
      if (w_frame_start) begin
        r_h <= '0;
        r_v <= '0;
      end else if (w_disp_fire) begin
        r_core_h   <= r_h;
        r_core_v   <= r_v;
        r_disp_ptr <= next_ptr(w_disp_grant);
        if (r_h == H_BITS'(DISPLAY_WIDTH - 1)) begin
          r_h <= '0;
          r_v <= r_v + V_BITS'(1);
        end else begin
          r_h <= r_h + H_BITS'(1);
        end
      end
    end
  end

  // Retire: registered ack, output pixel and retired count.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_core_ack <= '0;
      r_valid    <= 1'b0;
      r_hout     <= '0;
      r_vout     <= '0;
      r_color    <= '0;
      r_ret_ptr  <= '0;
      r_retired  <= '0;
    end else begin
      r_core_ack <= w_ret_grant;
      r_valid    <= w_ret_fire;
      if (w_ret_fire) begin
        r_hout    <= w_ret_h;
        r_vout    <= w_ret_v;
        r_color   <= w_ret_c;
        r_ret_ptr <= next_ptr(w_ret_grant);
      end
      if (w_frame_start)   r_retired <= '0;
      else if (w_ret_fire) r_retired <= r_retired + RET_W'(1);
    end
  end

  // Frame pulses and the fractal select held for the frame.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_new_frame  <= 1'b0;
      r_frame_done <= 1'b0;
      r_fsel       <= '0;
    end else begin
      r_new_frame  <= w_frame_start;
      r_frame_done <= (r_state == S_DRAIN) && (w_next_state == S_IDLE);
      if (w_frame_start) r_fsel <= fractal_sel_in;
    end
  end

  assign busy_out        = (r_state != S_IDLE);
  assign new_frame_out   = r_new_frame;
  assign frame_done_out  = r_frame_done;
  assign fractal_sel_out = r_fsel;
  assign core_start_out  = r_core_start;
  assign core_hcount_out = r_core_h;
  assign core_vcount_out = r_core_v;
  assign core_ack_out    = r_core_ack;
  assign hcount_out      = r_hout;
  assign vcount_out      = r_vout;
  assign color_out       = r_color;
  assign valid_out       = r_valid;
  assign state_dbg_out   = r_state;

endmodule

// File: tb/tb_march_scheduler.sv
// tb_march_scheduler: 4x2 display, two behavioural ray-march cores.
module tb_march_scheduler;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int N    = 2;
  localparam int HB   = $clog2(W);
  localparam int VB   = $clog2(H);
  localparam int NPIX = W * H;
  localparam int DW   = HB + VB;
  localparam int RW   = 1 + HB + VB + 4;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_in = 1'b0;
  logic [2:0] fsel_in = '0;
  logic busy_out, new_frame_out, frame_done_out, valid_out;
  logic [2:0] fractal_sel_out;
  logic [N-1:0] core_ready_in, core_start_out, core_done_in, core_ack_out;
  logic [HB-1:0] core_hcount_out, hcount_out;
  logic [VB-1:0] core_vcount_out, vcount_out;
  logic [N*HB-1:0] core_hcount_in;
  logic [N*VB-1:0] core_vcount_in;
  logic [N*4-1:0] core_color_in;
  logic [3:0] color_out;
  logic [1:0] state_dbg_out;

  always #5 clk = ~clk;

  march_scheduler #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .NUM_CORES(N)) dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start_in), .fractal_sel_in(fsel_in),
    .busy_out(busy_out), .new_frame_out(new_frame_out), .frame_done_out(frame_done_out),
    .fractal_sel_out(fractal_sel_out), .core_ready_in(core_ready_in),
    .core_start_out(core_start_out), .core_hcount_out(core_hcount_out),
    .core_vcount_out(core_vcount_out), .core_done_in(core_done_in),
    .core_hcount_in(core_hcount_in), .core_vcount_in(core_vcount_in),
    .core_color_in(core_color_in), .core_ack_out(core_ack_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .color_out(color_out),
    .valid_out(valid_out), .state_dbg_out(state_dbg_out));

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] color_fn(input logic [HB-1:0] h, input logic [VB-1:0] v);
    return ({1'b0, v, h} ^ 4'b1010) + 4'd3;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = 0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- behavioural cores ----------------
  logic ready_en = 1'b1;
  logic [N-1:0] m_idle = '1;
  logic [N-1:0] m_done = '0;
  logic [HB-1:0] m_h[N];
  logic [VB-1:0] m_v[N];
  logic [3:0] m_col[N];
  int lat[N];

  assign core_ready_in = m_idle & {N{ready_en}};
  assign core_done_in  = m_done;

  always_comb begin
    core_hcount_in = '0;
    core_vcount_in = '0;
    core_color_in  = '0;
    for (int i = 0; i < N; i++) begin
      core_hcount_in[i*HB +: HB] = m_h[i];
      core_vcount_in[i*VB +: VB] = m_v[i];
      core_color_in[i*4 +: 4]    = m_col[i];
    end
  end

  initial begin : core_model
    bit job[N];
    int cnt[N];
    logic [N-1:0] idle_n, done_n;
    logic [HB-1:0] h_n[N];
    logic [VB-1:0] v_n[N];
    logic [3:0] c_n[N];
    for (int i = 0; i < N; i++) begin
      job[i] = 0; cnt[i] = 0; lat[i] = 0;
      m_h[i] = '0; m_v[i] = '0; m_col[i] = '0;
    end
    forever begin
      @(negedge clk);
      idle_n = m_idle; done_n = m_done;
      for (int i = 0; i < N; i++) begin
        h_n[i] = m_h[i]; v_n[i] = m_v[i]; c_n[i] = m_col[i];
        if (!rst_n) begin
          idle_n[i] = 1'b1; done_n[i] = 1'b0; job[i] = 0;
        end else begin
          if (core_ack_out[i]) begin
            done_n[i] = 1'b0; idle_n[i] = 1'b1; job[i] = 0;
          end
          if (core_start_out[i]) begin
            job[i] = 1; idle_n[i] = 1'b0; cnt[i] = lat[i];
            h_n[i] = core_hcount_out; v_n[i] = core_vcount_out;
            c_n[i] = color_fn(core_hcount_out, core_vcount_out);
          end
          if (job[i] && !done_n[i]) begin
            if (cnt[i] == 0) done_n[i] = 1'b1;
            else cnt[i] = cnt[i] - 1;
          end
        end
      end
      @(posedge clk); #1;
      m_idle = idle_n; m_done = done_n;
      for (int i = 0; i < N; i++) begin
        m_h[i] = h_n[i]; m_v[i] = v_n[i]; m_col[i] = c_n[i];
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] exp_q[$];   // dispatch coordinates in raster order
  logic [RW-1:0] ret_q[$];   // {core, h, v, color} awaiting retire
  bit mon_en = 0;
  bit chk_alt = 0;
  bit exp_fd = 0;
  logic [2:0] exp_sel = '0;
  int n_disp = 0, n_valid = 0, n_nf = 0;
  int prev_dg = -1, prev_rg = -1;
  logic [HB-1:0] first_h;
  logic [VB-1:0] first_v;
  logic [N-1:0] prev_ready = '0;

  initial begin : monitor
    int gi, pos;
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("start_onehot", 32'($countones(core_start_out) <= 1), 32'd1);
        if (|core_start_out) begin
          gi = oh_idx(core_start_out);
          check("disp_core_was_ready", 32'(prev_ready[gi]), 32'd1);
          if (exp_q.size() == 0) check("disp_extra", 32'(n_disp), 32'(NPIX));
          else begin
            e = exp_q.pop_front();
            check("disp_coord", 32'({core_hcount_out, core_vcount_out}), 32'(e));
          end
          pos = -1;
          foreach (ret_q[k]) if (ret_q[k][RW-1] == 1'(gi)) pos = k;
          check("disp_to_inflight_core", 32'(pos), 32'hFFFF_FFFF);
          ret_q.push_back({1'(gi), core_hcount_out, core_vcount_out,
                           color_fn(core_hcount_out, core_vcount_out)});
          if (chk_alt && prev_dg >= 0) check("disp_alternate", 32'(gi), 32'(1 - prev_dg));
          prev_dg = gi;
          n_disp++;
        end
        check("ack_onehot", 32'($countones(core_ack_out) <= 1), 32'd1);
        check("valid_vs_ack", 32'(valid_out), 32'(|core_ack_out));
        if (valid_out) begin
          gi = oh_idx(core_ack_out);
          pos = -1;
          foreach (ret_q[k]) if (pos < 0 && ret_q[k][RW-1] == 1'(gi)) pos = k;
          if (pos < 0) check("retire_extra", 32'(gi), 32'hFFFF_FFFF);
          else begin
            check("retire_data", 32'({1'(gi), hcount_out, vcount_out, color_out}), 32'(ret_q[pos]));
            ret_q.delete(pos);
          end
          if (chk_alt && prev_rg >= 0) check("retire_alternate", 32'(gi), 32'(1 - prev_rg));
          prev_rg = gi;
          n_valid++;
          if (n_valid == 1) begin first_h = hcount_out; first_v = vcount_out; end
        end
        check("frame_done_timing", 32'(frame_done_out), 32'(exp_fd));
        if (frame_done_out) check("busy_at_done", 32'(busy_out), 32'd0);
        exp_fd = valid_out && (n_valid == NPIX);
        if (new_frame_out) n_nf++;
        if (busy_out) check("fsel_held", 32'(fractal_sel_out), 32'(exp_sel));
      end
      prev_ready = core_ready_in;
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    int lat0; int lat1;
    logic [2:0] sel; logic [2:0] sel_mid;
    bit restart; bit gap; bit alt;
    logic [HB-1:0] first_h; logic [VB-1:0] first_v;
  } vec_t;
  vec_t vecs[5];

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy_out), 0);
    check({tag, "_new_frame"}, 32'(new_frame_out), 0);
    check({tag, "_frame_done"}, 32'(frame_done_out), 0);
    check({tag, "_fsel"}, 32'(fractal_sel_out), 0);
    check({tag, "_core_start"}, 32'(core_start_out), 0);
    check({tag, "_core_h"}, 32'(core_hcount_out), 0);
    check({tag, "_core_v"}, 32'(core_vcount_out), 0);
    check({tag, "_ack"}, 32'(core_ack_out), 0);
    check({tag, "_hout"}, 32'(hcount_out), 0);
    check({tag, "_vout"}, 32'(vcount_out), 0);
    check({tag, "_color"}, 32'(color_out), 0);
    check({tag, "_valid"}, 32'(valid_out), 0);
    check({tag, "_state"}, 32'(state_dbg_out), 0);
  endtask

  task automatic prep_frame(input vec_t v);
    lat[0] = v.lat0; lat[1] = v.lat1;
    exp_sel = v.sel; chk_alt = v.alt;
    exp_q.delete(); ret_q.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) exp_q.push_back({HB'(x), VB'(y)});
    n_disp = 0; n_valid = 0; n_nf = 0; prev_dg = -1; prev_rg = -1;
  endtask

  task automatic start_frame(input logic [2:0] sel);
    @(posedge clk); #1; start_in = 1'b1; fsel_in = sel;   // cycle 0
    @(posedge clk); #1; start_in = 1'b0;                  // cycle 1
    @(negedge clk);
    check("new_frame_c1", 32'(new_frame_out), 1);
    check("busy_c1", 32'(busy_out), 1);
    check("no_start_c1", 32'(core_start_out), 0);
    check("fsel_c1", 32'(fractal_sel_out), 32'(sel));
    @(negedge clk);
    check("first_start_c2", 32'(|core_start_out), 1);
  endtask

  task automatic wait_disp(input int target);
    bit ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (n_disp >= target) ok = 1;
    end
    if (!ok) check("wait_disp_timeout", 32'(n_disp), 32'(target));
  endtask

  task automatic run_frame(input vec_t v);
    bit got = 0;
    prep_frame(v);
    start_frame(v.sel);
    if (v.restart) begin
      repeat (3) @(posedge clk);
      #1; fsel_in = v.sel_mid; start_in = 1'b1;
      @(posedge clk); #1; start_in = 1'b0;
    end
    if (v.gap) begin
      wait_disp(2);
      @(posedge clk); #1; ready_en = 1'b0;   // ready low from this cycle, 10 cycles
      @(negedge clk);
      for (int k = 1; k <= 9; k++) begin
        @(negedge clk);
        check("gap_no_dispatch", 32'(core_start_out), 0);
      end
      @(posedge clk); #1; ready_en = 1'b1;
      @(negedge clk);
      check("gap_no_dispatch_ready_back", 32'(core_start_out), 0);
      @(negedge clk);
      check("gap_resume", 32'(|core_start_out), 1);
    end
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (frame_done_out) got = 1;
    end
    if (!got) check("frame_done_timeout", 0, 1);
    check("n_dispatched", 32'(n_disp), 32'(NPIX));
    check("n_retired", 32'(n_valid), 32'(NPIX));
    check("n_new_frame", 32'(n_nf), 1);
    check("disp_queue_empty", 32'(exp_q.size()), 0);
    check("ret_queue_empty", 32'(ret_q.size()), 0);
    check("first_retired", 32'({first_h, first_v}), 32'({v.first_h, v.first_v}));
    check("fsel_after_frame", 32'(fractal_sel_out), 32'(v.sel));
    repeat (3) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    vec_t rv;
    // lat0 lat1 sel sel_mid restart gap alt first(h,v)
    vecs[0] = '{lat0: 3, lat1: 3, sel: 3'd1, sel_mid: 3'd0, restart: 0, gap: 0, alt: 1, first_h: 2'd0, first_v: 1'd0};
    vecs[1] = '{lat0: 0, lat1: 0, sel: 3'd6, sel_mid: 3'd0, restart: 0, gap: 0, alt: 1, first_h: 2'd0, first_v: 1'd0};
    vecs[2] = '{lat0: 6, lat1: 0, sel: 3'd4, sel_mid: 3'd0, restart: 0, gap: 0, alt: 0, first_h: 2'd1, first_v: 1'd0};
    vecs[3] = '{lat0: 2, lat1: 2, sel: 3'd5, sel_mid: 3'd2, restart: 1, gap: 0, alt: 1, first_h: 2'd0, first_v: 1'd0};
    vecs[4] = '{lat0: 1, lat1: 1, sel: 3'd7, sel_mid: 3'd0, restart: 0, gap: 1, alt: 0, first_h: 2'd0, first_v: 1'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1; rst_n = 1'b1; mon_en = 1;

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Reset in the middle of DISPATCH, then a clean frame from (0,0).
    rv = '{lat0: 2, lat1: 2, sel: 3'd3, sel_mid: 3'd0, restart: 0, gap: 0, alt: 1, first_h: 2'd0, first_v: 1'd0};
    prep_frame(rv);
    start_frame(rv.sel);
    wait_disp(3);
    check("busy_before_reset", 32'(busy_out), 1);
    @(posedge clk); #1; rst_n = 1'b0; mon_en = 0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1; rst_n = 1'b1; exp_fd = 0; mon_en = 1;
    repeat (2) @(posedge clk);
    rv.lat0 = 1; rv.lat1 = 1; rv.sel = 3'd2;
    run_frame(rv);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : watchdog
    #300000;
    n_err++;
    $display("FAIL watchdog: time limit reached, got no end of test, expected finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
